gol_population_counter: RTL and testbench
=========================================

# gol_population_counter

Post-generation census stage for the Game of Life fabric. When the HPS starts it (after the Game of Life engine reports completion), it scans the result grid through the shared on-chip memory port and counts live cells. The count, busy flag and a latched done flag are exported to HPS PIOs. While the block is scanning, top level muxes its memory address onto the on-chip memory port in place of the engine's address.

## Interface
Parameters:
- ADDR_W, 12, on-chip memory word address width
- DATA_W, 8, memory data width (one cell per word)
- DIM_W, 8, rows/columns width
- COUNT_W, 16, population width (covers 255×255 = 65025)

Ports:
- clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-high
- start  in  1  level from HPS PIO; a rising edge starts a census
- base_address  in  ADDR_W  first cell of the result grid
- rows  in  DIM_W  grid rows
- columns  in  DIM_W  grid columns
- mem_read_data  in  DATA_W  on-chip memory read data, valid one cycle after address
- mem_address  out  ADDR_W  read address, 0 when not active
- mem_active  out  1  block owns the memory port; top level forces write enable low and selects mem_address
- busy  out  1  census in progress
- done  out  1  latched completion flag to HPS PIO
- population  out  COUNT_W  live-cell count of the last completed census

## Operation
- A cell is live iff its word ≠ 0.
- States are IDLE, SCAN, DRAIN and DONE.
- IDLE/DONE → SCAN:
  - Triggered by a start rising edge (start=1, previous sample 0) when rows≠0 and columns≠0.
  - Latches base_address.
  - Registers total = rows*columns (full 16-bit product).
  - Clears the count and done.
- IDLE/DONE → DONE directly: a start rising edge with rows=0 or columns=0. population=0 and done=1; the memory port is never taken.
- SCAN:
  - Presents one address per cycle, starting at base and then incrementing.
  - Address arithmetic is modulo 2^ADDR_W, so the address wraps from 0xFFF to 0x000.
  - After the address of cell total-1 is issued, goes to DRAIN.
- Accumulation: a one-cycle valid pipeline flag qualifies mem_read_data; each qualified live cell adds 1 to the count.
- DRAIN: accumulates the final cell, then goes to DONE.
- DONE: publishes the count to population and holds done=1 until the next start edge or reset.
- start edges while busy are ignored. A start held high triggers exactly one census.
- Inputs are sampled only on the start edge; changes during a census have no effect.
- Reset at any time, including mid-scan, returns to IDLE. Outputs go to their reset values: mem_address=0, mem_active=0, busy=0, done=0, population=0.

## Timing
- Cycle 0 is the cycle where the start edge is sampled.
- Cell i address appears on mem_address in cycle 1+i; its data is sampled at the end of cycle 2+i.
- With N = rows*columns:
  - mem_active and busy are high in cycles 1..N+1.
  - done=1 and the final population are visible from cycle N+2.
  - Total latency is N+2 cycles.
- Zero-dimension case: done=1 and population=0 from cycle 1.
- population changes only on entry to DONE, or to 0 on a zero-dimension start or reset. It never shows partial counts.
- No overflow is possible: N ≤ 65025 < 2^16.

## Structure
- Package gol_pkg holds:
  - ADDR_W, DATA_W, DIM_W and COUNT_W defaults
  - the state enum (IDLE, SCAN, DRAIN, DONE)
- One sub-module, gol_edge_detect: registered rising-edge detector on start, reset to previous sample = 0.
- The remainder is the single FSM module: address counter, issued-cell counter, valid flag and accumulator.

## Test plan
- 3×4 grid at base 0x010 with 5 non-zero words, start pulse at cycle 0 → addresses 0x010..0x01B in cycles 1..12; population=5 and done=1 at cycle 14; busy low at cycle 14.
- rows=0, columns=7, start edge → done=1 and population=0 at cycle 1; mem_active never asserts.
- base 0xFFE, 2×2 grid, all words 0xFF → addresses 0xFFE, 0xFFF, 0x000, 0x001; population=4.
- start held high for 100 cycles on a 2×2 grid, plus a second edge during SCAN → exactly one census runs; a fresh edge after done clears done, then the census reruns with the same result.
- reset asserted at cycle 5 of a 4×4 scan → all outputs 0 on the next cycle; a subsequent start gives the correct full count.
- 64×64 grid, base 0, all cells live → population=4096, done at cycle 4098.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared widths and FSM encoding for the Game of Life census stage.
package gol_pkg;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 8;
   localparam int DIM_W   = 8;
   localparam int COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/gol_edge_detect.sv
// Rising-edge detector: flags sig high while its previous sample was low.
// Latency: combinational against a one-cycle-old registered sample.
// Backpressure: none; a held-high level yields a single one-cycle pulse.
module gol_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= sig;
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/gol_population_counter.sv
// Census of live cells in the Game of Life result grid via the shared memory port.
// Latency: rows*columns + 2 cycles from the sampled start edge to done.
// Backpressure: none; start edges during a census are ignored.
module gol_population_counter #(
   parameter int ADDR_W  = gol_pkg::ADDR_W,
   parameter int DATA_W  = gol_pkg::DATA_W,
   parameter int DIM_W   = gol_pkg::DIM_W,
   parameter int COUNT_W = gol_pkg::COUNT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_address,
   input  logic [DIM_W-1:0]   rows,
   input  logic [DIM_W-1:0]   columns,
   input  logic [DATA_W-1:0]  mem_read_data,
   output logic [ADDR_W-1:0]  mem_address,
   output logic               mem_active,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] population
);
   import gol_pkg::*;

   state_t               state_q;
   state_t               state_d;
   logic                 start_rise;
   logic                 dims_zero;
   logic                 active;
   logic                 live;
   logic [COUNT_W-1:0]   product;
   logic [COUNT_W-1:0]   count_next;
   logic [ADDR_W-1:0]    addr_q;
   logic [COUNT_W-1:0]   total_q;
   logic [COUNT_W-1:0]   issued_q;
   logic [COUNT_W-1:0]   count_q;
   logic [COUNT_W-1:0]   population_q;
   logic                 vld_q;
   logic                 done_q;

   gol_edge_detect u_start_edge (
      .clock (clock),
      .reset (reset),
      .sig   (start),
      .rise  (start_rise)
   );

   assign dims_zero  = (rows == '0) || (columns == '0);
   assign product    = COUNT_W'(rows) * COUNT_W'(columns);
   // Read data is qualified by vld_q, which trails the issued address by one cycle.
   assign live       = vld_q && (mem_read_data != '0);
   assign count_next = count_q + COUNT_W'(live);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start_rise) state_d = dims_zero ? DONE : SCAN;
         SCAN:       if (issued_q == total_q - COUNT_W'(1)) state_d = DRAIN;
         DRAIN:      state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         total_q      <= '0;
         issued_q     <= '0;
         count_q      <= '0;
         population_q <= '0;
         vld_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_q   <= (state_q == SCAN);
         case (state_q)
            IDLE, DONE: begin
               if (start_rise) begin
                  if (dims_zero) begin
                     population_q <= '0;
                     done_q       <= 1'b1;
                  end else begin
                     addr_q   <= base_address;
                     total_q  <= product;
                     issued_q <= '0;
                     count_q  <= '0;
                     done_q   <= 1'b0;
                  end
               end
            end
            SCAN: begin
               addr_q   <= addr_q + ADDR_W'(1);
               issued_q <= issued_q + COUNT_W'(1);
               count_q  <= count_next;
            end
            DRAIN: begin
               count_q      <= count_next;
               population_q <= count_next;
               done_q       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign active      = (state_q == SCAN) || (state_q == DRAIN);
   assign mem_active  = active;
   assign busy        = active;
   assign mem_address = active ? addr_q : '0;
   assign done        = done_q;
   assign population  = population_q;

endmodule

// File: tb/tb_gol_population_counter.sv
module tb_gol_population_counter;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int NW = 8;
   localparam int CW = 16;
   localparam int MEM_WORDS = 4096;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic [NW-1:0] rows = '0;
   logic [NW-1:0] columns = '0;
   logic [DW-1:0] mem_read_data = '0;
   logic [AW-1:0] mem_address;
   logic          mem_active;
   logic          busy;
   logic          done;
   logic [CW-1:0] population;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [0:MEM_WORDS-1];

   gol_population_counter dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .base_address  (base_address),
      .rows          (rows),
      .columns       (columns),
      .mem_read_data (mem_read_data),
      .mem_address   (mem_address),
      .mem_active    (mem_active),
      .busy          (busy),
      .done          (done),
      .population    (population)
   );

   always #5 clock = ~clock;

   // On-chip memory: data valid one cycle after the address.
   always @(posedge clock) mem_read_data <= mem[mem_address];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int count_live(input int b, input int n);
      int c = 0;
      for (int i = 0; i < n; i++)
         if (mem[(b + i) % MEM_WORDS] != 0) c++;
      return c;
   endfunction

   // Behavioural model: m_k is the cycle number relative to the accepted start edge.
   bit m_prev = 0;
   bit m_busy = 0;
   bit m_done = 0;
   int m_k    = 0;
   int m_n    = 0;
   int m_base = 0;
   int m_pop  = 0;
   int m_pend = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_prev = 0;
         m_busy = 0;
         m_done = 0;
         m_pop  = 0;
         m_k    = 0;
      end else begin
         bit rise;
         rise   = start && !m_prev;
         m_prev = start;
         if (m_busy) begin
            m_k++;
            if (m_k == m_n + 2) begin
               m_busy = 0;
               m_done = 1;
               m_pop  = m_pend;
            end
         end else if (rise) begin
            if (rows == 0 || columns == 0) begin
               m_done = 1;
               m_pop  = 0;
            end else begin
               m_busy = 1;
               m_k    = 1;
               m_base = int'(base_address);
               m_n    = int'(rows) * int'(columns);
               m_pend = count_live(m_base, m_n);
               m_done = 0;
            end
         end
      end
   end

   always @(negedge clock) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mem_active", 32'(mem_active), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("population", 32'(population), 32'(m_pop));
      if (!m_busy)
         chk("addr_idle", 32'(mem_address), 32'd0);
      else if (m_k <= m_n)
         chk("addr", 32'(mem_address), 32'((m_base + m_k - 1) % MEM_WORDS));
   end

   task automatic run_census(input int b, input int r, input int c,
                             input int exp_pop, input int exp_lat, input bit scramble);
      int lat;
      start = 1'b0;
      @(negedge clock);
      base_address = AW'(b);
      rows         = NW'(r);
      columns      = NW'(c);
      start        = 1'b1;
      lat = 0;
      while (lat < 70000) begin
         @(negedge clock);
         lat++;
         if (scramble && lat == 2) begin
            base_address = AW'($urandom);
            rows         = NW'($urandom);
            columns      = NW'($urandom);
         end
         if (done === 1'b1 && busy === 1'b0) break;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("pop_final", 32'(population), 32'(exp_pop));
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++)
         mem[i] = ($urandom % 2 == 0) ? 8'h00 : DW'($urandom_range(1, 255));

      repeat (3) @(negedge clock);
      chk("rst_population", 32'(population), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // 3x4 grid at 0x010 with five live words.
      for (int i = 'h10; i <= 'h1B; i++) mem[i] = 8'h00;
      mem['h10] = 8'h01; mem['h13] = 8'h80; mem['h15] = 8'h22;
      mem['h18] = 8'hFF; mem['h1B] = 8'h07;
      run_census('h010, 3, 4, 5, 14, 0);
      chk("t1_busy_low", 32'(busy), 32'd0);

      // Zero dimension: immediate done, memory untouched.
      run_census(0, 0, 7, 0, 1, 0);

      // Address wrap.
      mem['hFFE] = 8'hFF; mem['hFFF] = 8'hFF; mem['h000] = 8'hFF; mem['h001] = 8'hFF;
      run_census('hFFE, 2, 2, 4, 6, 0);

      // Start held high with an extra edge during the scan.
      mem['h100] = 8'h01; mem['h101] = 8'h00; mem['h102] = 8'h10; mem['h103] = 8'h40;
      start = 1'b0;
      @(negedge clock);
      base_address = 'h100; rows = 2; columns = 2; start = 1'b1;
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      repeat (97) @(negedge clock);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_pop", 32'(population), 32'd3);
      run_census('h100, 2, 2, 3, 6, 0);

      // Reset in the middle of a 4x4 scan.
      start = 1'b0;
      @(negedge clock);
      base_address = 'h200; rows = 4; columns = 4; start = 1'b1;
      repeat (5) @(negedge clock);
      #2;
      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      chk("midrst_population", 32'(population), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_active", 32'(mem_active), 32'd0);
      chk("midrst_addr", 32'(mem_address), 32'd0);
      reset = 1'b0;
      run_census('h200, 4, 4, count_live('h200, 16), 18, 0);

      // Random grids with inputs disturbed mid-census.
      repeat (6) begin
         int b, r, c;
         b = $urandom_range(0, MEM_WORDS - 1);
         r = $urandom_range(0, 9);
         c = $urandom_range(1, 9);
         run_census(b, r, c, count_live(b, r * c), (r * c == 0) ? 1 : r * c + 2, 1);
      end

      // Full 64x64 grid, all live.
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 8'hFF;
      run_census(0, 64, 64, 4096, 4098, 0);

      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
